// File: rtl/stream_dec_pkg.sv
// Shared definitions for the stream box decimator.
// Holds the default pixel geometry, the accumulator width that fits a full
// 2^MAX_SHIFT x 2^MAX_SHIFT box sum, the shift field width and the rounding
// helper used to turn a box sum into an average.
package stream_dec_pkg;

  localparam int DEF_CHANNELS  = 3;
  localparam int DEF_CH_W      = 8;
  localparam int DEF_RES_W     = 11;
  localparam int DEF_MAX_X_RES = 1024;
  localparam int DEF_MAX_SHIFT = 3;

  // Width of the x_shift / y_shift fields.
  localparam int SHIFT_W = $clog2(DEF_MAX_SHIFT + 1);

  // Box sum of up to 2^(2*MAX_SHIFT) full-scale channel values.
  localparam int ACC_W = DEF_CH_W + 2 * DEF_MAX_SHIFT;

  typedef logic [DEF_CH_W-1:0] chan_t;
  typedef chan_t [DEF_CHANNELS-1:0] pixel_t;  // channel 0 in the LSBs

  // Round-half-up divide by 2^s; s == 0 passes the value straight through.
  function automatic logic [31:0] rnd_shift(input logic [31:0] acc, input int unsigned s);
    if (s == 0) return acc;
    return (acc + (32'd1 << (s - 1))) >> s;
  endfunction

endpackage

// File: rtl/line_acc_ram.sv
// Column accumulator storage for the decimator.
// One entry per output column holds the partial vertical sum (or the kept
// top-left value in nearest mode) for all channels.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address (output column)
//   wdata  - packed per-channel accumulators
//   raddr  - read address, asynchronous read
//   rdata  - packed per-channel accumulators at raddr
// Contents are not reset; the first row of every group overwrites its entry.
module line_acc_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 42
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_box_decimator.sv
// Streaming power-of-two downscaler.
// Reduces a raster pixel stream by 2^x_shift horizontally and 2^y_shift
// vertically, emitting either the rounded box average or the top-left pixel
// of every full block, with frame/line markers for the sink.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   start                  - frame start: latch configuration, clear counters
//   in_x_res, in_y_res     - input width-1 / height-1
//   x_shift, y_shift       - log2 decimation factors
//   nearest                - 1 = top-left pick, 0 = box average
//   in_data/valid/ready    - input pixel stream
//   out_data/valid/ready   - output pixel stream
//   out_sof, out_eol       - first pixel of frame / last pixel of output line
//   frame_done             - pulse after the last output pixel is accepted
module stream_box_decimator
  import stream_dec_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int CH_W      = DEF_CH_W,
  parameter int RES_W     = DEF_RES_W,
  parameter int MAX_X_RES = DEF_MAX_X_RES,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             start,
  input  logic [RES_W-1:0]                 in_x_res,
  input  logic [RES_W-1:0]                 in_y_res,
  input  logic [$clog2(MAX_SHIFT+1)-1:0]   x_shift,
  input  logic [$clog2(MAX_SHIFT+1)-1:0]   y_shift,
  input  logic                             nearest,
  input  logic [CHANNELS*CH_W-1:0]         in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [CHANNELS*CH_W-1:0]         out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_sof,
  output logic                             out_eol,
  output logic                             frame_done
);

  localparam int SH_W     = $clog2(MAX_SHIFT + 1);
  localparam int ACC_BITS = CH_W + 2 * MAX_SHIFT;
  localparam int ADDR_W   = $clog2(MAX_X_RES);
  localparam int LINE_W   = CHANNELS * ACC_BITS;

  logic [RES_W-1:0]    x_res_q, y_res_q;
  logic [SH_W-1:0]     xs_q, ys_q;
  logic                nearest_q;
  logic                active;
  logic [RES_W-1:0]    in_x, in_y;
  logic [ACC_BITS-1:0] h_acc  [CHANNELS];
  logic [ACC_BITS-1:0] h_next [CHANNELS];
  logic [ACC_BITS-1:0] comb   [CHANNELS];

  logic [RES_W-1:0]    x_mask, y_mask, col, row;
  logic [RES_W:0]      out_w, out_h;
  logic [SH_W:0]       s_sum;
  logic                gx_first, gx_full, gy_first, gy_full;
  logic                xfer, load, last_in;
  logic                line_we;
  logic [LINE_W-1:0]   line_rd, line_wr;
  logic [ADDR_W-1:0]   line_addr;
  logic [CHANNELS*CH_W-1:0] out_next;
  logic                out_last;

  assign x_mask   = (RES_W'(1) << xs_q) - RES_W'(1);
  assign y_mask   = (RES_W'(1) << ys_q) - RES_W'(1);
  assign gx_first = (in_x & x_mask) == '0;
  assign gx_full  = (in_x & x_mask) == x_mask;
  assign gy_first = (in_y & y_mask) == '0;
  assign gy_full  = (in_y & y_mask) == y_mask;
  assign col      = in_x >> xs_q;
  assign row      = in_y >> ys_q;
  assign out_w    = ({1'b0, x_res_q} + (RES_W+1)'(1)) >> xs_q;
  assign out_h    = ({1'b0, y_res_q} + (RES_W+1)'(1)) >> ys_q;
  assign s_sum    = {1'b0, xs_q} + {1'b0, ys_q};
  assign line_addr = ADDR_W'(col);

  assign in_ready = active && (!out_valid || out_ready);
  // start wins over a same-cycle transfer: the offered pixel is dropped.
  assign xfer     = in_valid && in_ready && !start;
  assign last_in  = (in_x == x_res_q) && (in_y == y_res_q);
  // Only the last pixel of a full group in both axes produces an output;
  // partial trailing groups never reach the all-ones position.
  assign load     = xfer && gx_full && gy_full;
  assign line_we  = xfer && gx_full && !gy_full;

  always_comb begin
    line_wr  = '0;
    out_next = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      h_next[ch] = '0;
      comb[ch]   = '0;
      if (gx_first)       h_next[ch] = ACC_BITS'(in_data[ch*CH_W +: CH_W]);
      else if (nearest_q) h_next[ch] = h_acc[ch];
      else                h_next[ch] = h_acc[ch] + ACC_BITS'(in_data[ch*CH_W +: CH_W]);

      if (gy_first)       comb[ch] = h_next[ch];
      else if (nearest_q) comb[ch] = line_rd[ch*ACC_BITS +: ACC_BITS];
      else                comb[ch] = line_rd[ch*ACC_BITS +: ACC_BITS] + h_next[ch];

      line_wr[ch*ACC_BITS +: ACC_BITS] = comb[ch];
      if (nearest_q) out_next[ch*CH_W +: CH_W] = CH_W'(comb[ch]);
      else           out_next[ch*CH_W +: CH_W] = CH_W'(rnd_shift(32'(comb[ch]), 32'(s_sum)));
    end
  end

  line_acc_ram #(
    .DEPTH (MAX_X_RES),
    .WIDTH (LINE_W)
  ) u_line_acc (
    .clk   (clk),
    .we    (line_we),
    .waddr (line_addr),
    .wdata (line_wr),
    .raddr (line_addr),
    .rdata (line_rd)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_res_q    <= '0;
      y_res_q    <= '0;
      xs_q       <= '0;
      ys_q       <= '0;
      nearest_q  <= 1'b0;
      active     <= 1'b0;
      in_x       <= '0;
      in_y       <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) h_acc[ch] <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (start) begin
        x_res_q   <= in_x_res;
        y_res_q   <= in_y_res;
        xs_q      <= x_shift;
        ys_q      <= y_shift;
        nearest_q <= nearest;
        active    <= 1'b1;
        in_x      <= '0;
        in_y      <= '0;
        out_valid <= 1'b0;
      end else begin
        if (xfer) begin
          for (int ch = 0; ch < CHANNELS; ch++) h_acc[ch] <= h_next[ch];
          if (in_x == x_res_q) begin
            in_x <= '0;
            in_y <= in_y + RES_W'(1);
          end else begin
            in_x <= in_x + RES_W'(1);
          end
          if (last_in) active <= 1'b0;
        end
        if (load) begin
          out_valid <= 1'b1;
          out_data  <= out_next;
          out_sof   <= (col == '0) && (row == '0);
          out_eol   <= {1'b0, col} == out_w - (RES_W+1)'(1);
          out_last  <= ({1'b0, col} == out_w - (RES_W+1)'(1)) &&
                       ({1'b0, row} == out_h - (RES_W+1)'(1));
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_box_decimator.sv
module tb_stream_box_decimator;
  import stream_dec_pkg::*;

  logic               clk = 1'b0;
  logic               resetn;
  logic               start;
  logic [10:0]        in_x_res, in_y_res;
  logic [SHIFT_W-1:0] x_shift, y_shift;
  logic               nearest;
  logic [23:0]        in_data;
  logic               in_valid;
  logic               in_ready;
  logic [23:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sof, out_eol;
  logic               frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] first_out;

  always #5 clk = ~clk;

  stream_box_decimator dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .in_x_res   (in_x_res),
    .in_y_res   (in_y_res),
    .x_shift    (x_shift),
    .y_shift    (y_shift),
    .nearest    (nearest),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // pat 0: ramp y*w+x plus 40 per channel; pat 1: constant 255.
  function automatic int pix_val(int pat, int w, int x, int y, int ch);
    if (pat == 1) return 255;
    return y * w + x + 40 * ch;
  endfunction

  function automatic logic [23:0] pix24(int pat, int w, int x, int y);
    pixel_t pv;
    for (int ch = 0; ch < 3; ch++) pv[ch] = 8'(pix_val(pat, w, x, y, ch));
    return pv;
  endfunction

  task automatic run_frame(input string name, input int w, input int h, input int xs,
                           input int ys, input int near, input int pat, input int rnd,
                           input int abort_at, input bit do_start);
    logic [25:0] exp_q [$];
    logic [23:0] ev;
    int ow, oh, n_pix, idx, outs, dones, cyc, tail, sum, n;
    bit fi, fo;
    ow = w >> xs;
    oh = h >> ys;
    n  = xs + ys;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (near != 0) begin
            sum = pix_val(pat, w, ox << xs, oy << ys, ch);
          end else begin
            sum = 0;
            for (int by = 0; by < (1 << ys); by++)
              for (int bx = 0; bx < (1 << xs); bx++)
                sum += pix_val(pat, w, (ox << xs) + bx, (oy << ys) + by, ch);
            if (n > 0) sum = (sum + (1 << (n - 1))) >> n;
          end
          ev[ch*8 +: 8] = 8'(sum);
        end
        exp_q.push_back({(ox == 0 && oy == 0), (ox == ow - 1), ev});
      end

    if (do_start) begin
      @(negedge clk);
      start    = 1'b1;
      in_x_res = 11'(w - 1);
      in_y_res = 11'(h - 1);
      x_shift  = SHIFT_W'(xs);
      y_shift  = SHIFT_W'(ys);
      nearest  = near[0];
      in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
    end

    n_pix = w * h;
    idx = 0; outs = 0; dones = 0; cyc = 0; tail = 0;
    while (1) begin
      if (abort_at > 0 && idx == abort_at) break;
      if (idx == n_pix && outs == exp_q.size()) begin
        if (tail == 4) break;
        tail++;
      end
      if (cyc == 3000) begin
        chk({name, "_timeout"}, idx * 1000 + outs, n_pix * 1000 + exp_q.size());
        break;
      end
      out_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = idx < n_pix;
      in_data   = (idx < n_pix) ? pix24(pat, w, idx % w, idx / w) : 24'h0;
      #1;
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      if (frame_done) dones++;
      if (fo) begin
        if (outs == 0) first_out = out_data;
        if (outs < exp_q.size())
          chk($sformatf("%s_out%0d", name, outs), {out_sof, out_eol, out_data}, exp_q[outs]);
        else
          chk({name, "_extra_out"}, outs + 1, exp_q.size());
        outs++;
      end
      @(posedge clk);
      if (fi) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (abort_at == 0) begin
      chk({name, "_count"}, outs, exp_q.size());
      chk({name, "_done"}, dones, 1);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    in_x_res  = '0;
    in_y_res  = '0;
    x_shift   = '0;
    y_shift   = '0;
    nearest   = 1'b0;
    in_data   = 24'h123456;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    first_out = '0;
    #23;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_markers", {out_sof, out_eol, frame_done}, 0);
    in_valid = 1'b0;
    resetn = 1'b1;

    run_frame("ramp_avg", 8, 4, 1, 1, 0, 0, 0, 0, 1'b1);
    chk("ramp_avg_px0", first_out, 24'h552d05);

    run_frame("ramp_nn", 8, 4, 1, 1, 1, 0, 0, 0, 1'b1);
    chk("ramp_nn_px0", first_out, 24'h502800);

    run_frame("const255", 16, 16, 3, 3, 0, 1, 0, 0, 1'b1);
    chk("const255_px0", first_out, 24'hffffff);

    run_frame("partial", 10, 5, 2, 1, 0, 0, 0, 0, 1'b1);
    chk("partial_px0", first_out, 24'h572f07);

    run_frame("rand_rdy", 8, 8, 1, 1, 0, 0, 1, 0, 1'b1);

    // Abort mid-frame while an output is pending and the sink stalls.
    run_frame("abort", 8, 8, 1, 1, 0, 0, 0, 12, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    start     = 1'b1;
    in_x_res  = 11'd3;
    in_y_res  = 11'd3;
    x_shift   = SHIFT_W'(1);
    y_shift   = SHIFT_W'(1);
    nearest   = 1'b0;
    #1;
    chk("pre_abort_ov", out_valid, 1);
    @(negedge clk);
    // Second start with a pixel offered: the pixel must be dropped.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 24'habcdef;
    #1;
    chk("abort_ov", out_valid, 0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    run_frame("after_abort", 4, 4, 1, 1, 0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
